// File: rtl/vga_tile_renderer_pkg.sv
// Shared types and constants for the tile renderer.
//   color_code_t : 3-bit tile colour code (0 = empty, 1..7 = piece)
//   rgb_t        : 24-bit {R,G,B} pixel
//   state_t      : board-update controller states
//   PALETTE, BG_RGB, BORDER_RGB, GRID_RGB : pixel colour constants
package vga_render_pkg;

  typedef logic [2:0]  color_code_t;
  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP_WAIT
  } state_t;

  localparam rgb_t BG_RGB     = 24'h202020;
  localparam rgb_t BORDER_RGB = 24'h146450;
  localparam rgb_t GRID_RGB   = 24'h202020;

  localparam rgb_t PALETTE [8] = '{
    24'h000000, 24'h00FDFF, 24'hFFFF00, 24'hFF00FF,
    24'h0000FF, 24'hFF8000, 24'h00FF00, 24'hFF0000
  };

endpackage

// File: rtl/vga_tile_renderer_if.sv
// Board-update bus between game logic (master) and the renderer (slave).
//   wr_valid/wr_ready : back-buffer write handshake
//   wr_x, wr_y        : tile coordinates, wr_color : colour code
//   clr_req           : pulse, clear back buffer
//   swap_req          : pulse, publish back buffer at next vsync
//   swap_done         : pulse when front buffer has been loaded
interface vga_tile_renderer_if #(
  parameter int COLS = 10,
  parameter int ROWS = 20
);
  import vga_render_pkg::*;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [$clog2(COLS)-1:0] wr_x;
  logic [$clog2(ROWS)-1:0] wr_y;
  color_code_t             wr_color;
  logic                    clr_req;
  logic                    swap_req;
  logic                    swap_done;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, clr_req, swap_req,
    input  wr_ready, swap_done
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, clr_req, swap_req,
    output wr_ready, swap_done
  );

endinterface

// File: rtl/vga_tile_renderer_tile_board_buffer.sv
// Double-buffered tile store.
//   wr_en_i/wr_idx_i/wr_color_i : write one back-buffer tile
//   clr_en_i/clr_idx_i          : zero one back-buffer tile
//   copy_en_i                   : load whole front buffer from back buffer
//   rd_idx_i -> rd_color_o      : combinational front-buffer read
module tile_board_buffer
  import vga_render_pkg::*;
#(
  parameter int DEPTH = 200,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  color_code_t      wr_color_i,
  input  logic             clr_en_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic             copy_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output color_code_t      rd_color_o
);

  color_code_t back_q  [DEPTH];
  color_code_t front_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
    end else begin
      if (wr_en_i)   back_q[wr_idx_i]  <= wr_color_i;
      if (clr_en_i)  back_q[clr_idx_i] <= '0;
      if (copy_en_i) front_q <= back_q;
    end
  end

  always_comb begin
    rd_color_o = '0;
    if (int'(rd_idx_i) < DEPTH) rd_color_o = front_q[rd_idx_i];
  end

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile playfield renderer between VGA timing and the DAC pins.
//   clk, reset                : clock, async active-high reset
//   row, col, blank_in        : pixel position / blanking from VGA timing
//   hs_in, vs_in              : active-low syncs
//   bus                       : board-update bus (slave side)
//   rgb, hs_out, vs_out, blank_out : pixel and syncs, 2-cycle latency
module vga_tile_renderer
  import vga_render_pkg::*;
#(
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int TILE_W   = 16,
  parameter int TILE_H   = 20,
  parameter int ORIGIN_X = 240,
  parameter int ORIGIN_Y = 60,
  parameter int BORDER   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         row,
  input  logic [9:0]         col,
  input  logic               blank_in,
  input  logic               hs_in,
  input  logic               vs_in,
  vga_tile_renderer_if.slave bus,
  output rgb_t               rgb,
  output logic               hs_out,
  output logic               vs_out,
  output logic               blank_out
);

  localparam int DEPTH  = COLS * ROWS;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int GRID_W = COLS * TILE_W;
  localparam int GRID_H = ROWS * TILE_H;

  // ---------------- stage 1: classification ----------------
  int               dx_d, dy_d;
  logic             grid_d, border_d, line_d;
  logic [IDX_W-1:0] tile_d;

  logic             blank_s1_q, hs_s1_q, vs_s1_q;
  logic             grid_s1_q, border_s1_q, line_s1_q;
  logic [IDX_W-1:0] tile_s1_q;

  always_comb begin
    dx_d     = int'(col) - ORIGIN_X;
    dy_d     = int'(row) - ORIGIN_Y;
    grid_d   = (dx_d >= 0) && (dx_d < GRID_W) && (dy_d >= 0) && (dy_d < GRID_H);
    border_d = !grid_d &&
               (dx_d >= -BORDER) && (dx_d < GRID_W + BORDER) &&
               (dy_d >= -BORDER) && (dy_d < GRID_H + BORDER);
    line_d   = ((dx_d % TILE_W) == 0) || ((dy_d % TILE_H) == 0);
    tile_d   = '0;
    if (grid_d) tile_d = IDX_W'((dy_d / TILE_H) * COLS + dx_d / TILE_W);
  end

  // ---------------- stage 2: lookup and colour ----------------
  color_code_t tile_color;
  rgb_t        rgb_d;
  rgb_t        rgb_q;
  logic        hs_q, vs_q, blank_q;

  always_comb begin
    if (blank_s1_q)     rgb_d = '0;
    else if (grid_s1_q) rgb_d = line_s1_q ? GRID_RGB : PALETTE[tile_color];
    else if (border_s1_q) rgb_d = BORDER_RGB;
    else                rgb_d = BG_RGB;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_s1_q  <= 1'b1;
      hs_s1_q     <= 1'b1;
      vs_s1_q     <= 1'b1;
      grid_s1_q   <= 1'b0;
      border_s1_q <= 1'b0;
      line_s1_q   <= 1'b0;
      tile_s1_q   <= '0;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b1;
    end else begin
      blank_s1_q  <= blank_in;
      hs_s1_q     <= hs_in;
      vs_s1_q     <= vs_in;
      grid_s1_q   <= grid_d;
      border_s1_q <= border_d;
      line_s1_q   <= line_d;
      tile_s1_q   <= tile_d;
      rgb_q       <= rgb_d;
      hs_q        <= hs_s1_q;
      vs_q        <= vs_s1_q;
      blank_q     <= blank_s1_q;
    end
  end

  assign rgb       = rgb_q;
  assign hs_out    = hs_q;
  assign vs_out    = vs_q;
  assign blank_out = blank_q;

  // ---------------- board-update controller ----------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             vs_prev_q, wr_ready_q, swap_done_q;
  logic             vs_fall, clr_en, copy_en, wr_en, wr_in_range;
  logic [IDX_W-1:0] wr_idx;

  assign vs_fall = vs_prev_q && !vs_in;

  // wr_ready is registered from the next state so it reads 0 straight
  // out of reset and rises one cycle after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      clr_idx_q   <= '0;
      vs_prev_q   <= 1'b1;
      wr_ready_q  <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      vs_prev_q   <= vs_in;
      wr_ready_q  <= (state_d == IDLE);
      swap_done_q <= copy_en;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      IDLE: begin
        if (bus.clr_req) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
        end else if (bus.swap_req) begin
          state_d = SWAP_WAIT;
        end
      end
      CLEAR: begin
        if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
        else clr_idx_d = clr_idx_q + 1'b1;
      end
      SWAP_WAIT: begin
        if (vs_fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_en      = (state_q == CLEAR);
    copy_en     = (state_q == SWAP_WAIT) && vs_fall;
    wr_in_range = (int'(bus.wr_x) < COLS) && (int'(bus.wr_y) < ROWS);
    wr_en       = bus.wr_valid && wr_ready_q && wr_in_range;
    wr_idx      = IDX_W'(int'(bus.wr_y) * COLS + int'(bus.wr_x));
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.swap_done = swap_done_q;

  tile_board_buffer #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_board (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (wr_en),
    .wr_idx_i   (wr_idx),
    .wr_color_i (bus.wr_color),
    .clr_en_i   (clr_en),
    .clr_idx_i  (clr_idx_q),
    .copy_en_i  (copy_en),
    .rd_idx_i   (tile_s1_q),
    .rd_color_o (tile_color)
  );

endmodule
